// File: rtl/float_pkg.sv
// float_pkg: shared constants and FSM state type for the sequential float divider.
package float_pkg;
   localparam int MANT_W = 24;
   localparam int QUOT_W = 25;
   localparam logic [9:0] EXP_BIAS = 10'd127;
   localparam logic [7:0] EXP_MAX = 8'd255;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
endpackage

// File: rtl/float_div_seq_if.sv
// float_div_seq_if: start/busy/done handshake, operands, quotient and flags.
interface float_div_seq_if #(parameter int XLEN = 32);
   logic start;
   logic [XLEN-1:0] A, B;
   logic busy, done;
   logic [XLEN-1:0] result;
   logic overflow, underflow, exception;
   modport master (output start, A, B, input busy, done, result, overflow, underflow, exception);
   modport slave (input start, A, B, output busy, done, result, overflow, underflow, exception);
endinterface

// File: rtl/float_mant_div_core.sv
// float_mant_div_core: restoring mantissa divider, one quotient bit per step, MSB first.
module float_mant_div_core
   import float_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [MANT_W-1:0] ma_i,
   input  logic [MANT_W-1:0] mb_i,
   output logic [QUOT_W-1:0] quot_o,
   output logic [4:0]        cnt_o
);
   logic [QUOT_W-1:0] rem_q, quot_q, diff, keep;
   logic [MANT_W-1:0] mb_q;
   logic [4:0] cnt_q;
   logic ge;
   // remainder stays below 2*mB, so the shifted value always fits in 25 bits
   always_comb begin
      diff = rem_q - {1'b0, mb_q};
      ge = rem_q >= {1'b0, mb_q};
      keep = ge ? diff : rem_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quot_q <= '0;
         mb_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         rem_q <= {1'b0, ma_i};
         mb_q <= mb_i;
         quot_q <= '0;
         cnt_q <= '0;
      end else if (step_i) begin
         rem_q <= {keep[QUOT_W-2:0], 1'b0};
         quot_q <= {quot_q[QUOT_W-2:0], ge};
         cnt_q <= cnt_q + 5'd1;
      end
   end
   assign quot_o = quot_q;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/float_div_seq.sv
// float_div_seq: iterative single-precision divider, truncating, subnormals flushed to zero.
module float_div_seq
   import float_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst,
   float_div_seq_if.slave bus
);
   state_t state_q;
   logic busy_q, done_q, ovf_q, unf_q, exc_q, sign_q;
   logic [XLEN-1:0] result_q;
   logic signed [9:0] exp_q, exp_n;
   logic [7:0] ea, eb;
   logic [22:0] mant;
   logic [QUOT_W-1:0] quot;
   logic [4:0] cnt;
   logic sign_n, special, load;
   always_comb begin
      ea = bus.A[30:23];
      eb = bus.B[30:23];
      sign_n = bus.A[31] ^ bus.B[31];
      special = ea == EXP_MAX || eb == EXP_MAX || ea == 8'd0 || eb == 8'd0;
      load = state_q == IDLE && bus.start && !special;
      exp_n = quot[QUOT_W-1] ? exp_q : exp_q - 10'sd1;
      mant = quot[QUOT_W-1] ? quot[23:1] : quot[22:0];
   end
   float_mant_div_core u_core (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .step_i (state_q == DIVIDE),
      .ma_i   ({1'b1, bus.A[22:0]}),
      .mb_i   ({1'b1, bus.B[22:0]}),
      .quot_o (quot),
      .cnt_o  (cnt)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         exc_q <= 1'b0;
         sign_q <= 1'b0;
         exp_q <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.start) begin
               busy_q <= 1'b1;
               ovf_q <= 1'b0;
               unf_q <= 1'b0;
               exc_q <= 1'b0;
               sign_q <= sign_n;
               // specials resolve here and skip straight to DONE
               if (ea == EXP_MAX || eb == EXP_MAX) begin
                  result_q <= QNAN;
                  exc_q <= 1'b1;
               end else if (eb == 8'd0) begin
                  result_q <= {sign_n, 8'hFF, 23'h0};
                  exc_q <= 1'b1;
               end else if (ea == 8'd0) begin
                  result_q <= {sign_n, 31'h0};
               end
               exp_q <= $signed({2'b0, ea}) - $signed({2'b0, eb}) + $signed(EXP_BIAS);
               done_q <= special;
               state_q <= special ? DONE : DIVIDE;
            end
            DIVIDE: if (cnt == 5'(QUOT_W - 1)) state_q <= NORM;
            NORM: begin
               ovf_q <= exp_n >= $signed({2'b0, EXP_MAX});
               unf_q <= exp_n <= 10'sd0;
               result_q <= exp_n >= $signed({2'b0, EXP_MAX}) ? {sign_q, 8'hFF, 23'h0} :
                           exp_n <= 10'sd0 ? {sign_q, 31'h0} : {sign_q, exp_n[7:0], mant};
               done_q <= 1'b1;
               state_q <= DONE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.result = result_q;
   assign bus.overflow = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.exception = exc_q;
endmodule
